// File: rtl/temp_pkg.sv
// temp_pkg: shared types, constants and saturation helper for the temperature sensor front end.
package temp_pkg;
   typedef enum logic [1:0] {IDLE, SELECT, SHIFT, UPDATE} state_t;
   localparam int FRAME_BITS = 8;
   localparam logic [7:0] INVALID_CODE = 8'hFF;
   localparam logic [4:0] TEMP_MAX = 5'd31;
   localparam logic [4:0] TEMP_RESET = 5'd20;
   function automatic logic [4:0] saturate(input logic [9:0] sum);
      logic [7:0] avg;
      avg = 8'(sum >> 2);
      return (avg > 8'd31) ? TEMP_MAX : avg[4:0];
   endfunction
endpackage

// File: rtl/moving_avg4.sv
// moving_avg4: 4-deep sample history with priming load; presents the saturated average of the next history.
module moving_avg4
   import temp_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  prime,
   input  logic [FRAME_BITS-1:0] raw,
   output logic [4:0]            avg_next
);
   logic [3:0][FRAME_BITS-1:0] hist_q, hist_d;
   logic [9:0] sum;
   always_comb begin
      hist_d = prime ? {4{raw}} : load ? {hist_q[2:0], raw} : hist_q;
      sum = 10'(hist_d[0]) + 10'(hist_d[1]) + 10'(hist_d[2]) + 10'(hist_d[3]);
      avg_next = saturate(sum);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) hist_q <= '0;
      else hist_q <= hist_d;
endmodule

// File: rtl/temp_sensor_frontend.sv
// temp_sensor_frontend: periodic bit-serial sensor read, 4-sample moving average,
// saturation to 0..31 and absent-sensor detection.
module temp_sensor_frontend
   import temp_pkg::*;
#(
   parameter int SAMPLE_PERIOD = 1000,
   parameter int FAULT_LIMIT = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       sens_cs_n,
   output logic       sens_sclk,
   input  logic       sens_sdo,
   output logic [4:0] temperature,
   output logic       temp_valid,
   output logic       sensor_fault
);
   localparam int CW = $clog2(SAMPLE_PERIOD);
   localparam int FW = $clog2(FAULT_LIMIT + 1);
   state_t state_q, state_d;
   logic [3:0] k_q, k_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [FRAME_BITS-1:0] sh_q, sh_d;
   logic [FW-1:0] fail_q, fail_d;
   logic [4:0] temp_q, temp_d, avg_next;
   logic cs_n_q, cs_n_d, sclk_q, sclk_d;
   logic valid_q, valid_d, fault_q, fault_d, primed_q, primed_d;
   logic tc, upd, bad, good;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         k_q <= '0;
         cs_n_q <= 1'b1;
         sclk_q <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q <= k_d;
         cs_n_q <= cs_n_d;
         sclk_q <= sclk_d;
      end
   always_comb begin
      state_d = state_q;
      k_d = k_q;
      case (state_q)
         IDLE: if (tc) state_d = SELECT;
         SELECT: begin
            state_d = SHIFT;
            k_d = '0;
         end
         SHIFT: begin
            k_d = k_q + 4'd1;
            if (k_q == 4'd15) state_d = UPDATE;
         end
         default: state_d = IDLE;
      endcase
   end
   // Pins are registered from the next state so they line up with state_q.
   always_comb begin
      cs_n_d = !(state_d == SELECT || state_d == SHIFT);
      sclk_d = state_d == SHIFT && k_d[0];
   end
   assign tc = cnt_q == CW'(SAMPLE_PERIOD - 1);
   assign upd = state_q == UPDATE;
   assign bad = sh_q == INVALID_CODE;
   assign good = upd && !bad;
   always_comb begin
      cnt_d = tc ? '0 : cnt_q + CW'(1);
      sh_d = (state_q == SHIFT && k_q[0]) ? {sh_q[FRAME_BITS-2:0], sens_sdo} : sh_q;
      fail_d = good ? '0 : (upd && fail_q != FW'(FAULT_LIMIT)) ? fail_q + FW'(1) : fail_q;
      fault_d = upd ? (bad && fail_d == FW'(FAULT_LIMIT)) : fault_q;
      temp_d = good ? avg_next : temp_q;
      valid_d = good;
      primed_d = primed_q | good;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt_q <= '0;
         sh_q <= '0;
         fail_q <= '0;
         fault_q <= 1'b0;
         temp_q <= TEMP_RESET;
         valid_q <= 1'b0;
         primed_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sh_q <= sh_d;
         fail_q <= fail_d;
         fault_q <= fault_d;
         temp_q <= temp_d;
         valid_q <= valid_d;
         primed_q <= primed_d;
      end
   moving_avg4 u_avg (
      .clk(clk),
      .rst_n(rst_n),
      .load(good),
      .prime(good && !primed_q),
      .raw(sh_q),
      .avg_next(avg_next)
   );
   assign sens_cs_n = cs_n_q;
   assign sens_sclk = sclk_q;
   assign temperature = temp_q;
   assign temp_valid = valid_q;
   assign sensor_fault = fault_q;
endmodule

// File: doc/temp_sensor_frontend.md
# temp_sensor_frontend

Upstream stage of the air-conditioning controller. It periodically reads an 8-bit whole-degree temperature from an external bit-serial sensor and filters it with a 4-sample moving average. The result is saturated to 0..31 and presented as the 5-bit `temperature` bus consumed by the heater/cooler control FSM. It also flags a missing or faulty sensor.

## Interface
- `SAMPLE_PERIOD`, 1000: clock cycles between conversion starts; must be ≥ 19.
- `FAULT_LIMIT`, 3: consecutive invalid reads before `sensor_fault` asserts.
- `clk` in 1: single system clock; all logic rises on its positive edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sens_cs_n` out 1: sensor chip select, low during a frame.
- `sens_sclk` out 1: serial clock to the sensor, clk/2 during the frame.
- `sens_sdo` in 1: serial data from the sensor, MSB first.
- `temperature` out 5: filtered, saturated temperature in °C; held between updates.
- `temp_valid` out 1: one-cycle pulse when `temperature` has just been updated.
- `sensor_fault` out 1: level; high while the sensor is considered absent.

## Operation
- Free-running period counter runs 0..SAMPLE_PERIOD-1 and wraps. Terminal count starts a frame. The FSM is always IDLE at that point, given the constraint on SAMPLE_PERIOD.
- FSM states and transitions:
  - IDLE: cs_n=1, sclk=0. Goes to SELECT on terminal count.
  - SELECT: 1 cycle, cs_n=0, sclk=0.
  - SHIFT: 16 cycles, k=0..15. sclk=k[0]. `sens_sdo` is captured at the end of each odd k into bit 7-(k>>1).
  - UPDATE: 1 cycle, cs_n=1, sclk=0. Goes back to IDLE.
- Invalid read: raw == 8'hFF (sensor absent, line pulled up).
  - Sample is discarded; history and `temperature` are unchanged; no `temp_valid`.
  - Fail counter increments, saturating at FAULT_LIMIT. `sensor_fault`=1 when the counter equals FAULT_LIMIT.
- Valid read: fail counter clears to 0 and `sensor_fault` clears to 0.
  - If this is the first valid read since reset, all 4 history slots are loaded with the raw value (priming, no ramp from 0).
  - Otherwise the history shifts in the raw value and drops the oldest.
  - Computation: sum = 10-bit sum of the 4 slots. avg = sum>>2 (truncating). temperature = avg>31 ? 31 : avg[4:0].
- Reset values: temperature=5'd20 (controller idles until real data arrives), temp_valid=0, sensor_fault=0, sens_cs_n=1, sens_sclk=0. History is cleared, the priming flag is cleared, and the period counter is 0.
- Reset asserted mid-frame: frame is aborted immediately and asynchronously, with cs_n=1 and sclk=0. No partial sample is used.

## Timing
- Terminal-count edge → SELECT next cycle. Full frame is 18 cycles (SELECT + 16 SHIFT + UPDATE).
- `temperature` and `temp_valid` are registered at the end of UPDATE. They are visible in the cycle after UPDATE, 18 cycles after the FSM leaves IDLE.
- `temp_valid` is high for exactly 1 cycle per valid read.
- `sensor_fault` changes in the same cycle `temperature` would have.
- First frame starts SAMPLE_PERIOD cycles after reset release.
- Outputs are glitch-free registers. `sens_sclk` and `sens_cs_n` are driven from flops.

## Structure
- Package `temp_pkg`:
  - FSM state enum {IDLE, SELECT, SHIFT, UPDATE}.
  - FRAME_BITS=8, INVALID_CODE=8'hFF, TEMP_MAX=5'd31, TEMP_RESET=5'd20.
- Sub-module `moving_avg4`: 4×8-bit history, priming load, shift, sum, divide, saturate. Inputs are load/prime strobes.
- Top level holds the FSM, period counter, shift register and fault counter.

## Test plan
- Reset, no frame yet → temperature=20, temp_valid=0, cs_n=1, sclk=0, sensor_fault=0.
- Sensor model returns 22 on the first frame → cs_n low for 17 cycles; temp_valid pulses 18 cycles after SELECT; temperature=22 (priming).
- Reads 18, 18, 18, 18 after priming at 22 → temperature reaches 21, 20, 19, 18 on successive valid pulses.
- Raw 200 → saturates: temperature=31.
- Three 8'hFF reads → sensor_fault=1 after the third, temperature unchanged, no temp_valid pulses. Next valid read of 19 → fault clears, temp_valid pulses, average updated.
- rst_n pulsed low at SHIFT k=7 → cs_n=1 immediately, temperature=20. Next frame proceeds normally with a fresh priming load.
